// File: rtl/sdram_arbit.sv
// sdram_arbit: single owner of the SDRAM command/address/DQ pins.
// Grants init, then refresh > write > read, one at a time.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111,
  parameter int         DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [12:0]       init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_bank,
  input  logic [12:0]       aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [12:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              wr_sdram_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [12:0]       rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [12:0]       sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  state_t state_q, state_d;
  logic   aref_en_q, aref_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;
  logic   cke_q;
  logic [3:0] cmd;

  // Next state and grants; an end pulse only counts for the owner.
  always_comb begin
    state_d   = state_q;
    aref_en_d = aref_en_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    unique case (state_q)
      S_IDLE: begin
        if (init_end) state_d = S_ARBIT;
      end
      S_ARBIT: begin
        if (aref_req) begin
          state_d   = S_AREF;
          aref_en_d = 1'b1;
        end else if (wr_req) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
        end
      end
      S_AREF: begin
        if (aref_end) begin
          state_d   = S_ARBIT;
          aref_en_d = 1'b0;
        end
      end
      S_WRITE: begin
        if (wr_end) begin
          state_d = S_ARBIT;
          wr_en_d = 1'b0;
        end
      end
      S_READ: begin
        if (rd_end) begin
          state_d = S_ARBIT;
          rd_en_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase
  end

  // State and grant registers; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cke_q     <= 1'b1;
    end
  end

  // Pin mux follows the current owner.
  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = 2'b11;
    sdram_addr = 13'h1fff;
    unique case (state_q)
      S_IDLE: begin
        cmd        = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_bank;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_bank;
        sdram_addr = wr_addr;
      end
      S_READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1fff;
      end
    endcase
  end

  // DQ is only ever driven by the write owner.
  always_comb begin
    sdram_dq_oe  = (state_q == S_WRITE) && wr_sdram_en;
    sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = cke_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scoreboard bench for sdram_arbit.
// Stimulus pushes expected pin snapshots; a negedge monitor pops them.
module tb_sdram_arbit;

  localparam int ST_I = 0;
  localparam int ST_A = 1;
  localparam int ST_F = 2;
  localparam int ST_W = 3;
  localparam int ST_R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b0;
  logic [3:0]  init_cmd = 4'h1;
  logic [1:0]  init_bank = 2'd1;
  logic [12:0] init_addr = 13'h0111;
  logic        aref_req = 1'b0;
  logic        aref_end = 1'b0;
  logic [3:0]  aref_cmd = 4'h2;
  logic [1:0]  aref_bank = 2'd2;
  logic [12:0] aref_addr = 13'h0222;
  logic        wr_req = 1'b0;
  logic        wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'h3;
  logic [1:0]  wr_bank = 2'd3;
  logic [12:0] wr_addr = 13'h0333;
  logic [15:0] wr_sdram_data = 16'h0000;
  logic        wr_sdram_en = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h4;
  logic [1:0]  rd_bank = 2'd0;
  logic [12:0] rd_addr = 13'h0444;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;

  sdram_arbit #(.CMD_NOP(4'b0111), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_bank(aref_bank), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end),
    .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_sdram_data(wr_sdram_data), .wr_sdram_en(wr_sdram_en),
    .rd_req(rd_req), .rd_end(rd_end),
    .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [39:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {aref_en,wr_en,rd_en,cke,cmd,ba,addr,oe,dq}
  function automatic logic [39:0] model(int st, logic oe, logic [15:0] dq);
    logic [22:0] en_pins;
    case (st)
      ST_I:    en_pins = {3'b000, 1'b1, 4'h1, 2'd1, 13'h0111};
      ST_A:    en_pins = {3'b000, 1'b1, 4'b0111, 2'b11, 13'h1fff};
      ST_F:    en_pins = {3'b100, 1'b1, 4'h2, 2'd2, 13'h0222};
      ST_W:    en_pins = {3'b010, 1'b1, 4'h3, 2'd3, 13'h0333};
      default: en_pins = {3'b001, 1'b1, 4'h4, 2'd0, 13'h0444};
    endcase
    return {en_pins, oe, dq};
  endfunction

  task automatic tick(string nm, int st, logic oe = 1'b0,
                      logic [15:0] dq = 16'h0);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm = nm;
    e.v  = model(st, oe, dq);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: the DUT presents pins every cycle; compare on negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [39:0] act;
      e   = q.pop_front();
      act = {aref_en, wr_en, rd_en, sdram_cke,
             sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out};
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end

  initial begin
    // reset and init
    repeat (3) tick("reset", ST_I);
    rst = 1'b0;
    tick("idle_no_init", ST_I);
    tick("idle_hold", ST_I);
    init_end = 1'b1;
    tick("enter_arbit", ST_A);
    tick("arbit_idle", ST_A);

    // single write with DQ
    wr_req = 1'b1;
    tick("wr_grant", ST_W);
    wr_req = 1'b0;
    tick("wr_beat_noen", ST_W);
    wr_sdram_en = 1'b1;
    wr_sdram_data = 16'h0005;
    tick("wr_dq", ST_W, 1'b1, 16'h0005);
    wr_sdram_en = 1'b0;
    wr_end = 1'b1;
    tick("wr_end_nop", ST_A);
    wr_end = 1'b0;
    tick("after_wr", ST_A);

    // three simultaneous requests
    aref_req = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    tick("prio_aref", ST_F);
    aref_req = 1'b0;
    tick("aref_busy", ST_F);
    aref_end = 1'b1;
    tick("aref_end_nop", ST_A);
    aref_end = 1'b0;
    tick("prio_wr", ST_W);
    wr_req = 1'b0;
    wr_end = 1'b1;
    tick("wr_end_nop2", ST_A);
    wr_end = 1'b0;
    tick("prio_rd", ST_R);
    rd_req = 1'b0;
    wr_sdram_en = 1'b1;
    wr_sdram_data = 16'h0005;
    tick("rd_no_dq", ST_R);
    wr_sdram_en = 1'b0;
    rd_end = 1'b1;
    tick("rd_end_nop", ST_A);
    rd_end = 1'b0;
    tick("arbit_empty", ST_A);

    // refresh request arriving mid-write is deferred
    wr_req = 1'b1;
    tick("wr2_grant", ST_W);
    wr_req = 1'b0;
    tick("wr2_beat2", ST_W);
    aref_req = 1'b1;
    for (int i = 3; i <= 9; i++) tick("wr2_no_preempt", ST_W);
    wr_end = 1'b1;
    tick("wr2_end_nop", ST_A);
    wr_end = 1'b0;
    tick("aref_after_wr", ST_F);
    aref_req = 1'b0;
    aref_end = 1'b1;
    tick("aref2_end", ST_A);
    aref_end = 1'b0;

    // spurious end pulses
    wr_end = 1'b1;
    tick("spur_wr_end", ST_A);
    wr_end = 1'b0;
    rd_end = 1'b1;
    tick("spur_rd_end", ST_A);
    rd_end = 1'b0;
    wr_req = 1'b1;
    tick("wr3_grant", ST_W);
    wr_req = 1'b0;
    aref_end = 1'b1;
    rd_end = 1'b1;
    tick("spur_in_wr", ST_W);
    aref_end = 1'b0;
    rd_end = 1'b0;
    wr_end = 1'b1;
    tick("wr3_end", ST_A);
    wr_end = 1'b0;

    // reset in the middle of a read
    rd_req = 1'b1;
    tick("rd2_grant", ST_R);
    rd_req = 1'b0;
    tick("rd2_beat", ST_R);
    rst = 1'b1;
    tick("rst_mid_rd", ST_I);
    rst = 1'b0;
    tick("reinit_arbit", ST_A);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Command arbiter directly downstream of sdram_init, sdram_write, sdram_read and sdram_aref.
- Grants one sub-module at a time and drives its command, bank, address and DQ onto the SDRAM pins.
- Fixed priority: auto-refresh > write > read.
- Replaces the ad-hoc init/write muxing used in early benches; it is the single owner of the SDRAM bus.

Parameters:
- CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} driven when no sub-module owns the bus.
- DATA_W, 16, DQ width.

Ports:
- clk  in  1  100 MHz controller clock.
- rst  in  1  synchronous reset, active-high.
- init_end  in  1  initialisation complete (sticky high).
- init_cmd / init_bank / init_addr  in  4/2/13  init command bus.
- aref_req  in  1  refresh request, held until granted.
- aref_end  in  1  refresh sequence done, 1-cycle pulse.
- aref_cmd / aref_bank / aref_addr  in  4/2/13  refresh command bus.
- wr_req  in  1  write request, held until granted.
- wr_end  in  1  write burst done, 1-cycle pulse.
- wr_cmd / wr_bank / wr_addr  in  4/2/13  write command bus.
- wr_sdram_data  in  DATA_W  write data.
- wr_sdram_en  in  1  write data valid (DQ drive).
- rd_req  in  1  read request, held until granted.
- rd_end  in  1  read burst done, 1-cycle pulse.
- rd_cmd / rd_bank / rd_addr  in  4/2/13  read command bus.
- aref_en  out  1  grant to refresh module.
- wr_en  out  1  grant to write module.
- rd_en  out  1  grant to read module.
- sdram_cke  out  1  clock enable.
- sdram_cs_n / sdram_ras_n / sdram_cas_n / sdram_we_n  out  1 each  command pins.
- sdram_ba  out  2  bank.
- sdram_addr  out  13  address.
- sdram_dq_out  out  DATA_W  DQ output data.
- sdram_dq_oe  out  1  DQ output enable (top level builds the tristate).

Behaviour:
- States: IDLE, ARBIT, AREF, WRITE, READ. One-hot or binary encoding, registered.
- Reset (rst=1 at a clk edge, including mid-burst):
  - state=IDLE; aref_en=wr_en=rd_en=0; sdram_cke=1.
  - Pins follow the IDLE mux.
  - Sub-modules are reset by the same rst; no end pulse is awaited.
- IDLE:
  - Pins = init_cmd/init_bank/init_addr.
  - init_end=1 -> ARBIT next cycle.
  - Never re-entered except by reset.
- ARBIT:
  - Pins = CMD_NOP, ba=2'b11, addr=13'h1fff.
  - aref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay in ARBIT.
  - Priority is evaluated in a single cycle.
  - Simultaneous requests: the highest priority wins; losers keep their req asserted and are served on a later ARBIT pass.
- Grant enables:
  - Registered; set on the same edge that enters AREF/WRITE/READ.
  - Cleared on the edge where the matching *_end=1.
  - At most one enable is high at any time; a grant is never pre-empted.
- AREF:
  - Pins = aref_cmd/aref_bank/aref_addr.
  - aref_end=1 -> ARBIT and aref_en=0 on the same edge.
- WRITE:
  - Pins = wr_cmd/wr_bank/wr_addr.
  - wr_end -> ARBIT.
  - Requests arriving mid-burst (e.g. aref_req) are ignored until ARBIT.
- READ:
  - Pins = rd_cmd/rd_bank/rd_addr.
  - rd_end -> ARBIT.
- *_end asserted for a non-owning module: ignored, no state change.
- Pin muxing:
  - Pin/bus muxing is combinational from the current state.
  - Latency request->grant = 1 cycle from ARBIT.
  - Each ARBIT visit costs exactly 1 NOP cycle between grants.
- DQ:
  - sdram_dq_oe = (state==WRITE) & wr_sdram_en.
  - sdram_dq_out = wr_sdram_data when oe=1, else 0.
  - DQ is never driven outside WRITE.

Test Plan:
- Hold rst=1 for 3 cycles, then release with init_end=0 -> all enables 0, pins equal init_* bus. Raise init_end -> ARBIT one cycle later with pins = 4'b0111 / 2'b11 / 13'h1fff.
- In ARBIT, pulse wr_req=1 with init_end=1 -> wr_en=1 on the next edge. Pins track wr_cmd. Pulse wr_end -> wr_en=0 and one NOP cycle follows.
- Assert aref_req, wr_req and rd_req together -> aref_en first. After aref_end: wr_en. After wr_end: rd_en. Each grant is separated by exactly 1 NOP cycle.
- During WRITE, raise aref_req at burst beat 3 of 10 -> wr_en stays 1 until wr_end, then aref_en=1 two cycles after wr_end.
- In WRITE with wr_sdram_en=1 and wr_sdram_data=16'h0005 -> dq_oe=1 and dq_out=16'h0005. In READ, dq_oe is always 0.
- Assert rst=1 mid-READ -> next edge: state IDLE, rd_en=0, pins = init bus. Spurious wr_end in ARBIT -> no change.
